// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three 2-entry result FIFOs (ALU, branch, mem) feed one
// registered broadcast port through round-robin arbitration with mispredict flush.
module cdb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  src_valid,
  output logic [2:0]  src_ready,
  input  logic [20:0] src_preg,
  input  logic [95:0] src_data,
  input  logic [14:0] src_rob_tag,
  input  logic [2:0]  src_has_dest,
  output logic        cdb_valid,
  output logic [6:0]  cdb_preg,
  output logic [31:0] cdb_data,
  output logic [4:0]  cdb_rob_tag,
  output logic        cdb_has_dest,
  output logic [1:0]  cdb_src,
  input  logic [4:0]  rob_head,
  input  logic        mispredict,
  input  logic [4:0]  mispredict_tag
);

  typedef struct packed {
    logic [6:0]  preg;
    logic [31:0] data;
    logic [4:0]  rob_tag;
    logic        has_dest;
  } entry_t;

  entry_t     fifo_q   [3][2];
  entry_t     fifo_d   [3][2];
  entry_t     surv     [3][2];
  entry_t     in_entry [3];
  logic [1:0] count_q  [3];
  logic [1:0] count_d  [3];
  logic [1:0] surv_cnt [3];
  logic [1:0] remain   [3];
  logic [2:0] keep_head;
  logic [2:0] keep_tail;
  logic [2:0] cand;
  logic [2:0] push;
  logic [2:0] pop;
  logic [1:0] rr_q;
  logic [1:0] rr_d;
  logic [1:0] grant;
  logic [1:0] scan;
  logic       grant_valid;

  // Ages are distances from the ROB head, so wrap-around of the 5-bit tag space is harmless.
  function automatic logic is_younger(input logic [4:0] tag, input logic [4:0] head,
                                      input logic [4:0] flush_tag);
    logic [4:0] tag_age;
    logic [4:0] flush_age;
    tag_age   = tag - head;
    flush_age = flush_tag - head;
    return tag_age > flush_age;
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      src_ready[i] = (count_q[i] < 2'd2);
    end
  end

  // Flush survivors are compacted toward the head before arbitration sees them.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      in_entry[i]  = {src_preg[i*7 +: 7], src_data[i*32 +: 32], src_rob_tag[i*5 +: 5],
                      src_has_dest[i]};
      keep_head[i] = (count_q[i] != 2'd0) &&
                     !(mispredict && is_younger(fifo_q[i][0].rob_tag, rob_head, mispredict_tag));
      keep_tail[i] = (count_q[i] == 2'd2) &&
                     !(mispredict && is_younger(fifo_q[i][1].rob_tag, rob_head, mispredict_tag));
      surv[i][0]   = keep_head[i] ? fifo_q[i][0] : fifo_q[i][1];
      surv[i][1]   = fifo_q[i][1];
      surv_cnt[i]  = {1'b0, keep_head[i]} + {1'b0, keep_tail[i]};
      cand[i]      = (surv_cnt[i] != 2'd0);
      push[i]      = src_valid[i] && src_ready[i] &&
                     !(mispredict && is_younger(src_rob_tag[i*5 +: 5], rob_head, mispredict_tag));
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant       = rr_q;
    scan        = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!grant_valid && cand[scan]) begin
        grant_valid = 1'b1;
        grant       = scan;
      end
      scan = next_idx(scan);
    end
    rr_d = grant_valid ? next_idx(grant) : rr_q;
  end

  // A push only happens below two entries, so after pop at most one survivor remains.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pop[i]       = grant_valid && (grant == 2'(i));
      remain[i]    = surv_cnt[i] - {1'b0, pop[i]};
      fifo_d[i][0] = pop[i] ? surv[i][1] : surv[i][0];
      fifo_d[i][1] = surv[i][1];
      count_d[i]   = remain[i];
      if (push[i]) begin
        if (remain[i] == 2'd0) begin
          fifo_d[i][0] = in_entry[i];
        end else begin
          fifo_d[i][1] = in_entry[i];
        end
        count_d[i] = remain[i] + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 2; j++) begin
        fifo_q[i][j] <= fifo_d[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        count_q[i] <= 2'd0;
      end
      rr_q         <= 2'd0;
      cdb_valid    <= 1'b0;
      cdb_preg     <= 7'd0;
      cdb_data     <= 32'd0;
      cdb_rob_tag  <= 5'd0;
      cdb_has_dest <= 1'b0;
      cdb_src      <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        count_q[i] <= count_d[i];
      end
      rr_q      <= rr_d;
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_preg     <= surv[grant][0].preg;
        cdb_data     <= surv[grant][0].data;
        cdb_rob_tag  <= surv[grant][0].rob_tag;
        cdb_has_dest <= surv[grant][0].has_dest;
        cdb_src      <= grant;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_cdb_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [20:0] src_preg;
  logic [95:0] src_data;
  logic [14:0] src_rob_tag;
  logic [2:0]  src_has_dest;
  logic        cdb_valid;
  logic [6:0]  cdb_preg;
  logic [31:0] cdb_data;
  logic [4:0]  cdb_rob_tag;
  logic        cdb_has_dest;
  logic [1:0]  cdb_src;
  logic [4:0]  rob_head;
  logic        mispredict;
  logic [4:0]  mispredict_tag;

  cdb_arbiter dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_preg(src_preg), .src_data(src_data), .src_rob_tag(src_rob_tag),
    .src_has_dest(src_has_dest),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data),
    .cdb_rob_tag(cdb_rob_tag), .cdb_has_dest(cdb_has_dest), .cdb_src(cdb_src),
    .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  preg;
    logic [31:0] data;
    logic [4:0]  tag;
    logic        hd;
  } ent_t;

  ent_t        m_q [3][$];
  int          m_rr;
  logic        exp_valid;
  logic [6:0]  exp_preg;
  logic [31:0] exp_data;
  logic [4:0]  exp_tag;
  logic        exp_hd;
  logic [1:0]  exp_src;
  logic [2:0]  exp_ready;
  logic        started;
  int          checks;
  int          errors;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic model_younger(input logic [4:0] tag);
    logic [4:0] a_t;
    logic [4:0] a_m;
    a_t = tag - rob_head;
    a_m = mispredict_tag - rob_head;
    return a_t > a_m;
  endfunction

  // Reference behaviour: flush, then grant from survivors in rotating order, then accept pushes.
  always @(posedge clk) begin
    logic [2:0] rdy;
    ent_t       tmp[$];
    ent_t       e;
    logic       gv;
    int         s;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_q[i].delete();
      m_rr      = 0;
      exp_valid = 1'b0;
      exp_preg  = '0;
      exp_data  = '0;
      exp_tag   = '0;
      exp_hd    = 1'b0;
      exp_src   = '0;
    end else begin
      for (int i = 0; i < 3; i++) rdy[i] = (m_q[i].size() < 2);
      if (mispredict) begin
        for (int i = 0; i < 3; i++) begin
          tmp.delete();
          foreach (m_q[i][j]) if (!model_younger(m_q[i][j].tag)) tmp.push_back(m_q[i][j]);
          m_q[i] = tmp;
        end
      end
      gv = 1'b0;
      for (int k = 0; k < 3; k++) begin
        s = (m_rr + k) % 3;
        if (!gv && m_q[s].size() > 0) begin
          gv       = 1'b1;
          e        = m_q[s].pop_front();
          exp_preg = e.preg;
          exp_data = e.data;
          exp_tag  = e.tag;
          exp_hd   = e.hd;
          exp_src  = 2'(s);
        end
      end
      if (gv) m_rr = (int'(exp_src) + 1) % 3;
      exp_valid = gv;
      for (int i = 0; i < 3; i++) begin
        if (src_valid[i] && rdy[i] && !(mispredict && model_younger(src_rob_tag[i*5 +: 5]))) begin
          e.preg = src_preg[i*7 +: 7];
          e.data = src_data[i*32 +: 32];
          e.tag  = src_rob_tag[i*5 +: 5];
          e.hd   = src_has_dest[i];
          m_q[i].push_back(e);
        end
      end
    end
    for (int i = 0; i < 3; i++) exp_ready[i] = (m_q[i].size() < 2);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      checkOutput("m_cdb_valid", cdb_valid, exp_valid);
      checkOutput("m_src_ready", src_ready, exp_ready);
      checkOutput("m_cdb_src", cdb_src, exp_src);
      checkOutput("m_cdb_preg", cdb_preg, exp_preg);
      checkOutput("m_cdb_data", cdb_data, exp_data);
      checkOutput("m_cdb_rob_tag", cdb_rob_tag, exp_tag);
      checkOutput("m_cdb_has_dest", cdb_has_dest, exp_hd);
    end
  end

  task automatic applyStimulus(input int s, input logic [6:0] p, input logic [31:0] d,
                               input logic [4:0] t, input logic hd);
    src_valid[s]         = 1'b1;
    src_preg[s*7 +: 7]   = p;
    src_data[s*32 +: 32] = d;
    src_rob_tag[s*5 +: 5] = t;
    src_has_dest[s]      = hd;
  endtask

  task automatic tick();
    @(negedge clk);
    src_valid  = '0;
    mispredict = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    started = 1'b0;
    reset = 1'b1;
    src_valid = '0; src_preg = '0; src_data = '0; src_rob_tag = '0; src_has_dest = '0;
    rob_head = '0; mispredict = 1'b0; mispredict_tag = '0;
    tick(); tick();
    reset = 1'b0;
    checkOutput("rst_valid", cdb_valid, 0);
    checkOutput("rst_ready", src_ready, 3'b111);
    checkOutput("rst_data", cdb_data, 0);
    tick();

    // Single ALU result: two-cycle latency, one-cycle pulse, payload held.
    applyStimulus(0, 7'd40, 32'hDEAD_BEEF, 5'd3, 1'b1);
    tick();
    checkOutput("t1_early_valid", cdb_valid, 0);
    tick();
    checkOutput("t1_valid", cdb_valid, 1);
    checkOutput("t1_src", cdb_src, 0);
    checkOutput("t1_data", cdb_data, 32'hDEAD_BEEF);
    checkOutput("t1_preg", cdb_preg, 40);
    checkOutput("t1_tag", cdb_rob_tag, 3);
    tick();
    checkOutput("t1_drop_valid", cdb_valid, 0);
    checkOutput("t1_hold_data", cdb_data, 32'hDEAD_BEEF);

    // Three simultaneous pushes with rr at 0.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(i, 7'(10 + i), 32'h1000_0000 + i, 5'(5 + i), 1'b1);
    tick(); tick();
    checkOutput("t2_g0", cdb_src, 0);
    tick();
    checkOutput("t2_g1", cdb_src, 1);
    tick();
    checkOutput("t2_g2", cdb_src, 2);
    tick();
    checkOutput("t2_idle", cdb_valid, 0);
    applyStimulus(0, 7'd1, 32'h2000_0000, 5'd9, 1'b1);
    applyStimulus(2, 7'd2, 32'h2000_0002, 5'd10, 1'b0);
    tick(); tick();
    checkOutput("t2_rr_back0", cdb_src, 0);
    tick();
    checkOutput("t2_rr_then2", cdb_src, 2);

    // Mem backs up behind ALU and branch traffic.
    for (int i = 0; i < 3; i++) applyStimulus(i, 7'(20 + i), 32'hA000_0001 + 32'(i) * 32'h100, 5'(11 + i), 1'b1);
    applyStimulus(2, 7'd22, 32'h3000_0001, 5'd13, 1'b1);
    tick();
    for (int i = 0; i < 2; i++) applyStimulus(i, 7'(23 + i), 32'hA000_0002 + 32'(i) * 32'h100, 5'(14 + i), 1'b1);
    applyStimulus(2, 7'd25, 32'h3000_0002, 5'd16, 1'b1);
    tick();
    checkOutput("t3_ready_full", src_ready, 3'b001);
    checkOutput("t3_a1", cdb_data, 32'hA000_0001);
    applyStimulus(2, 7'd26, 32'h3000_0003, 5'd17, 1'b1);
    tick();
    checkOutput("t3_b1", cdb_data, 32'hA000_0101);
    checkOutput("t3_ready_mem_blocked", src_ready, 3'b011);
    tick();
    checkOutput("t3_m1", cdb_data, 32'h3000_0001);
    checkOutput("t3_m1_src", cdb_src, 2);
    tick(); tick(); tick();
    checkOutput("t3_m2", cdb_data, 32'h3000_0002);
    tick();
    checkOutput("t3_no_m3", cdb_valid, 0);

    // Flush with head at 30: tag 31 survives, tags 1 and 4 go, mem FIFO compacts.
    rob_head = 5'd30;
    applyStimulus(2, 7'd30, 32'h4000_0004, 5'd4, 1'b1);
    applyStimulus(0, 7'd31, 32'h4000_001E, 5'd30, 1'b1);
    tick();
    applyStimulus(2, 7'd32, 32'h4000_001F, 5'd31, 1'b1);
    applyStimulus(1, 7'd33, 32'h4000_0001, 5'd1, 1'b1);
    tick();
    checkOutput("t4_old_tag30", cdb_rob_tag, 30);
    mispredict = 1'b1; mispredict_tag = 5'd0;
    tick();
    checkOutput("t4_survivor_tag", cdb_rob_tag, 31);
    checkOutput("t4_survivor_src", cdb_src, 2);
    tick();
    checkOutput("t4_flushed_gone", cdb_valid, 0);
    tick();

    // Flush races with a younger and an older push.
    mispredict = 1'b1; mispredict_tag = 5'd0;
    applyStimulus(0, 7'd40, 32'h5000_0002, 5'd2, 1'b1);
    applyStimulus(1, 7'd41, 32'h5000_001F, 5'd31, 1'b1);
    tick();
    checkOutput("t5_ready", src_ready, 3'b111);
    tick();
    checkOutput("t5_older_tag", cdb_rob_tag, 31);
    checkOutput("t5_older_src", cdb_src, 1);
    tick();
    checkOutput("t5_younger_dropped", cdb_valid, 0);

    // Reset over loaded FIFOs beats pushes and flush.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) applyStimulus(i, 7'(50 + i), 32'h6000_0000 + 32'(r * 4 + i), 5'(20 + r * 3 + i), 1'b1);
      tick();
    end
    reset = 1'b1;
    mispredict = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(i, 7'(60 + i), 32'h7000_0000 + i, 5'(28 + i), 1'b1);
    tick();
    reset = 1'b0;
    checkOutput("t6_valid", cdb_valid, 0);
    checkOutput("t6_ready", src_ready, 3'b111);
    checkOutput("t6_data", cdb_data, 0);
    tick();
    checkOutput("t6_no_stale1", cdb_valid, 0);
    tick();
    checkOutput("t6_no_stale2", cdb_valid, 0);

    // Mixed traffic checked by the model alone.
    for (int c = 0; c < 120; c++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 2) != 0)
          applyStimulus(i, 7'($urandom), $urandom, 5'($urandom), 1'($urandom));
      end
      rob_head = 5'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        mispredict = 1'b1;
        mispredict_tag = 5'($urandom);
      end
      tick();
    end
    for (int c = 0; c < 8; c++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 src_valid  input  3  per-source result valid; bit0=ALU, bit1=branch, bit2=mem.
REQ-004 src_ready  output  3  per-source accept; bit i high when source i FIFO count < 2.
REQ-005 src_preg  input  3x7  destination physical register per source.
REQ-006 src_data  input  3x32  result data per source.
REQ-007 src_rob_tag  input  3x5  ROB tag per source.
REQ-008 src_has_dest  input  3  result writes PRF (0 for stores/branches without rd).
REQ-009 cdb_valid  output  1  broadcast valid; drives PRF write, ROB complete and wakeup.
REQ-010 cdb_preg / cdb_data / cdb_rob_tag / cdb_has_dest  output  7/32/5/1  broadcast payload.
REQ-011 cdb_src  output  2  index of granted source (0..2).
REQ-012 rob_head  input  5  current ROB head, used for age computation.
REQ-013 mispredict  input  1  one-cycle flush pulse from ROB.
REQ-014 mispredict_tag  input  5  ROB tag of mispredicting branch.

Function
REQ-015 Per source: 2-entry in-order FIFO {preg,data,rob_tag,has_dest}; 2-bit count, 0..2.
REQ-016 Push on src_valid[i] && src_ready[i]; src_ready[i] = (count_i < 2), from registered state only, no dependence on same-cycle pop.
REQ-017 Candidates each cycle: sources with count_i > 0; arbitration considers FIFO heads only, no input bypass.
REQ-018 Round-robin: 2-bit pointer rr (0..2); grant first candidate at index rr, rr+1, rr+2 (mod 3); on grant rr <= grant+1 mod 3; rr unchanged when no candidate.
REQ-019 Granted head popped same edge that loads output register; cdb_* registered.
REQ-020 Min latency: push at edge N -> cdb_valid high in cycle after edge N+1 (2 cycles).
REQ-021 No candidate -> cdb_valid <= 0; payload holds previous value.
REQ-022 Push and pop on same source same edge: count unchanged, order preserved.
REQ-023 Age(tag) = (tag - rob_head) mod 32, 5-bit unsigned; entry younger iff Age(tag) > Age(mispredict_tag).
REQ-024 On mispredict: delete all FIFO entries younger than mispredict_tag; block same-cycle pushes with younger tags; mispredict_tag entry and older survive.
REQ-025 Survivors compact to head preserving order; count updated same edge.
REQ-026 Flush cycle arbitration uses only surviving heads; rr updates normally.
REQ-027 cdb_valid presented during flush cycle is not retracted (already broadcast).
REQ-028 A FIFO that is full with no pop holds; no overflow, no drop, no reordering.

Reset
REQ-029 reset: all counts 0, rr=0, cdb_valid=0, cdb_preg=0, cdb_data=0, cdb_rob_tag=0, cdb_has_dest=0, cdb_src=0; src_ready=3'b111 in cycle after reset.
REQ-030 reset dominates mispredict and pushes in same cycle; in-flight entries discarded.

Verification
REQ-031 Single ALU push {preg=7'd40,data=32'hDEAD_BEEF,tag=3} at edge N -> cdb_valid=1, cdb_src=0, same payload after edge N+1 only; cdb_valid=0 next cycle.
REQ-032 All three push same cycle, rr=0 -> grants 0,1,2 on three consecutive cycles; rr=0 afterwards.
REQ-033 Mem pushes 2 results while blocked by higher-priority traffic -> src_ready[2]=0 while count=2; third src_valid not accepted; both delivered in order.
REQ-034 rob_head=30, entries tags 31,1,4 queued, mispredict_tag=0 -> tags 31 survives, 1 and 4 deleted; only tag 31 broadcast.
REQ-035 Mispredict same cycle as younger-tag push and older-tag push on different sources -> younger not stored, older broadcast.
REQ-036 reset asserted with all FIFOs full -> cdb_valid=0 next cycle, src_ready=3'b111, no stale broadcast.
